// File: rtl/fpga_mem_pkg.sv
// Shared definitions for the on-chip memory blocks: M10K geometry,
// arbiter state encoding and the read-response tag carried down the
// read-latency pipeline.
package fpga_mem_pkg;

  localparam int M10K_ADDR_W = 8;
  localparam int M10K_DATA_W = 32;
  localparam int M10K_BE_W   = 4;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } rd_tag_t;

endpackage

// File: rtl/m10k_arbiter_rr_picker.sv
// Pure-combinational round-robin picker: returns a one-hot grant for the
// first asserted request found when scanning upward from the pointer,
// wrapping modulo N. Shared by the memory arbiters.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [PTR_W-1:0] sel;

  // Scan ptr, ptr+1, ... and keep only the first hit
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      sel = PTR_W'((int'(ptr) + i) % N);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m10k_arbiter.sv
// Shares one single-port M10K between NUM_REQ requesters. One beat is
// granted per cycle (round-robin, or held by a locking requester), the
// RAM bus is driven combinationally from the winner, and read data is
// steered back to the issuing requester READ_LATENCY+1 cycles later.
import fpga_mem_pkg::*;

module m10k_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = M10K_ADDR_W,
  parameter int DATA_W       = M10K_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*4-1:0]        req_be,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        ram_chipselect,
  output logic                        ram_write,
  output logic [ADDR_W-1:0]           ram_address,
  output logic [3:0]                  ram_byteenable,
  output logic [DATA_W-1:0]           ram_writedata,
  input  logic [DATA_W-1:0]           ram_readdata
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t       state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [PTR_W-1:0] gnt_idx;
  logic [NUM_REQ-1:0] rr_gnt;
  logic             any_gnt;
  rd_tag_t          tag_in;
  rd_tag_t [READ_LATENCY-1:0] tag_pipe;

  rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .req (req),
    .ptr (ptr),
    .gnt (rr_gnt)
  );

  // Grant: round-robin winner in ARB, only the owner in LOCKED, nothing while reset is held
  always_comb begin
    gnt = '0;
    if (reset_n) begin
      if (state == ARB) begin
        gnt = rr_gnt;
      end else begin
        gnt[owner] = req[owner];
      end
    end
  end

  // Encode the one-hot grant into the winning requester index
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign any_gnt        = |(req & gnt);
  assign ram_chipselect = any_gnt;

  // RAM bus muxed from the winner; idle bus is all zeros so nothing stale leaks out
  always_comb begin
    ram_write      = 1'b0;
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] && req[i]) begin
        ram_write      = req_write[i];
        ram_address    = req_addr[i*ADDR_W +: ADDR_W];
        ram_byteenable = req_be[i*4 +: 4];
        ram_writedata  = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next pointer, state and owner; a lock-less owner idle cycle releases the RAM
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    if (any_gnt) begin
      ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      case (state)
        ARB: begin
          if (req_lock[gnt_idx]) begin
            state_nxt = LOCKED;
            owner_nxt = gnt_idx;
          end
        end
        LOCKED: begin
          if (!req_lock[gnt_idx]) state_nxt = ARB;
        end
        default: state_nxt = ARB;
      endcase
    end else if (state == LOCKED && !req_lock[owner]) begin
      state_nxt = ARB;
    end
  end

  // Arbitration state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Tag for the beat accepted this cycle; writes carry no response
  always_comb begin
    tag_in.valid = any_gnt & ~ram_write;
    tag_in.id    = 3'(gnt_idx);
  end

  // Delay read tags by the RAM latency so they line up with ram_readdata
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Register the response so the RAM output path sees only one flop of logic
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (tag_pipe[READ_LATENCY-1].valid) begin
        rdata <= ram_readdata;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (tag_pipe[READ_LATENCY-1].id == 3'(i)) rvalid[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_m10k_arbiter.sv
// Bench for m10k_arbiter: behavioural M10K, a reference arbiter/memory
// model, and a scoreboard of expected read responses checked by an
// independent monitor.
module tb_m10k_arbiter;
  import fpga_mem_pkg::*;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RL = 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  logic [NR-1:0]    req, req_write, req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*4-1:0]  req_be;
  logic [NR-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata;
  logic             ram_chipselect, ram_write;
  logic [AW-1:0]    ram_address;
  logic [3:0]       ram_byteenable;
  logic [DW-1:0]    ram_writedata;
  logic [DW-1:0]    ram_readdata;

  logic [AW-1:0] addrA [NR];
  logic [DW-1:0] dataA [NR];
  logic [3:0]    beA   [NR];

  logic [DW-1:0] ramMem [256];
  logic [DW-1:0] refMem [256];

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } resp_t;

  resp_t expQ[$];
  resp_t e;

  int checks     = 0;
  int errors     = 0;
  int cycleCount = 0;
  int modelPtr   = 0;
  int modelOwner = -1;

  m10k_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (req),
    .req_write      (req_write),
    .req_lock       (req_lock),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_readdata   (ram_readdata)
  );

  always #5 clock = ~clock;

  // Cycle counter used to check response latency
  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Behavioural single-port M10K with one cycle of read latency
  always @(posedge clock) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byteenable[b]) ramMem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
        end
      end else begin
        ram_readdata <= ramMem[ram_address];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of requests, check grant/bus against the model, record expected reads
  task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR-1:0] w, input logic [NR-1:0] l);
    int k;
    int j;
    logic [NR-1:0] expGnt;
    logic [DW-1:0] merged;
    req       = r;
    req_write = w;
    req_lock  = l;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = addrA[i];
      req_wdata[i*DW +: DW] = dataA[i];
      req_be[i*4 +: 4]      = beA[i];
    end
    @(negedge clock);
    k = -1;
    if (modelOwner >= 0) begin
      if (r[modelOwner]) k = modelOwner;
    end else begin
      for (int off = 0; off < NR; off++) begin
        j = (modelPtr + off) % NR;
        if (k < 0 && r[j]) k = j;
      end
    end
    expGnt = (k >= 0) ? NR'(1 << k) : '0;
    checkOutput("gnt", 32'(gnt), 32'(expGnt));
    checkOutput("ram_chipselect", 32'(ram_chipselect), (k >= 0) ? 32'd1 : 32'd0);
    checkOutput("ram_write", 32'(ram_write), (k >= 0 && w[k]) ? 32'd1 : 32'd0);
    checkOutput("ram_address", 32'(ram_address), (k >= 0) ? 32'(addrA[k]) : 32'd0);
    if (k >= 0 && w[k]) begin
      checkOutput("ram_byteenable", 32'(ram_byteenable), 32'(beA[k]));
      checkOutput("ram_writedata", ram_writedata, dataA[k]);
    end
    if (k >= 0) begin
      if (w[k]) begin
        merged = refMem[addrA[k]];
        for (int b = 0; b < 4; b++) begin
          if (beA[k][b]) merged[b*8 +: 8] = dataA[k][b*8 +: 8];
        end
        refMem[addrA[k]] = merged;
      end else begin
        expQ.push_back('{due: cycleCount + RL + 1, id: k, data: refMem[addrA[k]]});
      end
      modelPtr = (k + 1) % NR;
      if (modelOwner < 0) begin
        if (l[k]) modelOwner = k;
      end else if (!l[k]) begin
        modelOwner = -1;
      end
    end else if (modelOwner >= 0 && !l[modelOwner]) begin
      modelOwner = -1;
    end
    @(posedge clock);
    #1;
  endtask

  // Hold reset for two cycles with every requester active, then release
  task automatic doReset();
    reset_n   = 1'b0;
    expQ.delete();
    modelPtr   = 0;
    modelOwner = -1;
    req       = '1;
    req_write = '0;
    req_lock  = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checkOutput("reset_gnt", 32'(gnt), 32'd0);
      checkOutput("reset_chipselect", 32'(ram_chipselect), 32'd0);
      checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
      checkOutput("reset_rdata", rdata, 32'd0);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 10 && expQ.size() > 0; n++) applyStimulus('0, '0, '0);
    checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: every presented response must match the head of the scoreboard
  always @(negedge clock) begin
    if (reset_n) begin
      if (rvalid != '0) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rvalid actual=%b required=none", rvalid);
        end else begin
          e = expQ.pop_front();
          checkOutput("rvalid", 32'(rvalid), 32'(1 << e.id));
          checkOutput("rdata", rdata, e.data);
          checkOutput("resp_cycle", 32'(cycleCount), 32'(e.due));
        end
      end else if (expQ.size() > 0 && expQ[0].due < cycleCount) begin
        e = expQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missing_rvalid actual=none required=id%0d at cycle %0d", e.id, e.due);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      addrA[i] = '0;
      dataA[i] = '0;
      beA[i]   = 4'hF;
    end
    $display("[TB] reset with all requesters active");
    doReset();

    $display("[TB] round-robin sequence from pointer 0");
    for (int i = 0; i < NR; i++) begin
      addrA[i] = AW'(8'h80 + i);
      dataA[i] = 32'hC0DE_0000 + i;
    end
    for (int c = 0; c < 5; c++) applyStimulus('1, '1, '0);

    $display("[TB] write then read-after-write");
    addrA[2] = 8'h10; dataA[2] = 32'hDEADBEEF; beA[2] = 4'hF;
    applyStimulus(4'b0100, 4'b0100, '0);
    addrA[0] = 8'h10;
    applyStimulus(4'b0001, '0, '0);

    $display("[TB] locked burst by requester 1");
    addrA[0] = 8'h80; addrA[3] = 8'h83;
    addrA[1] = 8'h30; dataA[1] = 32'h1111_0000; beA[1] = 4'hF;
    applyStimulus(4'b1011, 4'b0010, 4'b0010);
    applyStimulus(4'b1011, 4'b0010, 4'b0010);
    applyStimulus(4'b1011, 4'b0010, 4'b0010);
    applyStimulus(4'b1011, 4'b0010, 4'b0000);
    applyStimulus(4'b1001, '0, '0);
    drain();

    $display("[TB] interleaved back-to-back reads");
    addrA[0] = 8'h00; dataA[0] = 32'h1; beA[0] = 4'hF;
    addrA[3] = 8'hFF; dataA[3] = 32'h2; beA[3] = 4'hF;
    applyStimulus(4'b0001, 4'b0001, '0);
    applyStimulus(4'b1000, 4'b1000, '0);
    for (int c = 0; c < 6; c++) applyStimulus(4'b1001, '0, '0);
    drain();

    $display("[TB] partial byte-enable write");
    addrA[1] = 8'h20; dataA[1] = 32'h12345678; beA[1] = 4'hF;
    applyStimulus(4'b0010, 4'b0010, '0);
    dataA[1] = 32'hAAAA5555; beA[1] = 4'b0011;
    applyStimulus(4'b0010, 4'b0010, '0);
    applyStimulus(4'b0010, '0, '0);
    drain();

    $display("[TB] reset one cycle after an accepted read");
    addrA[0] = 8'h10;
    applyStimulus(4'b0001, '0, '0);
    doReset();
    for (int c = 0; c < 3; c++) applyStimulus('0, '0, '0);
    for (int i = 0; i < NR; i++) addrA[i] = AW'(8'h80 + i);
    applyStimulus('1, '0, '0);
    drain();

    $display("[TB] preload random window");
    for (int a = 0; a < 8; a++) begin
      addrA[a % NR] = AW'(8'h40 + a);
      dataA[a % NR] = $urandom;
      beA[a % NR]   = 4'hF;
      applyStimulus(NR'(1 << (a % NR)), NR'(1 << (a % NR)), '0);
    end

    $display("[TB] randomized traffic");
    for (int c = 0; c < 300; c++) begin
      logic [NR-1:0] r, w, l;
      for (int i = 0; i < NR; i++) begin
        addrA[i] = AW'(8'h40 + $urandom_range(0, 7));
        dataA[i] = $urandom;
        beA[i]   = 4'($urandom_range(0, 15));
        l[i]     = ($urandom_range(0, 3) == 0);
      end
      r = NR'($urandom_range(0, 15));
      w = NR'($urandom_range(0, 15));
      applyStimulus(r, w, l);
    end
    applyStimulus('0, '0, '0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m10k_arbiter.md
Name: m10k_arbiter

Overview:
- Shares one single-port M10K block (256 x 32) between NUM_REQ independent requesters, e.g. weight loader, activation writer and host readback.
- Round-robin arbitration grants one access per cycle and drives the RAM chipselect/write/address/byteenable/writedata bus.
- Read data is routed back to the issuing requester after the fixed RAM read latency.
- An optional lock lets one requester hold the RAM for a burst.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, RAM word-address width
- DATA_W, 32, RAM data width
- READ_LATENCY, 1, cycles from accepted read to readdata valid at the RAM (1..3)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester access request
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  hold ownership after this beat
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_be  in  NUM_REQ*4  packed byte enables
- gnt  out  NUM_REQ  one-hot, combinational; beat accepted when req[i] & gnt[i]
- rvalid  out  NUM_REQ  one-hot, read data valid for requester i
- rdata  out  DATA_W  read data, broadcast to all requesters
- ram_chipselect  out  1  RAM select
- ram_write  out  1  RAM write strobe
- ram_address  out  ADDR_W  RAM address
- ram_byteenable  out  4  RAM byte enables
- ram_writedata  out  DATA_W  RAM write data
- ram_readdata  in  DATA_W  RAM read data, valid READ_LATENCY cycles after the read

Behaviour:
- Reset (async assert, sync deassert upstream):
  - gnt=0, rvalid=0, rdata=0, ram_chipselect=0, ram_write=0.
  - Priority pointer=0, state=ARB, owner=0, response pipeline cleared.
  - Reset mid-burst or mid-read drops all in-flight reads; no rvalid follows.
- States:
  - ARB: gnt = first requester with req=1, searching pointer, pointer+1, ... mod NUM_REQ. At most one gnt bit is set; gnt=0 when req=0.
  - LOCKED: gnt[owner]=req[owner]; all other gnt bits are 0.
- Transitions, on an accepted beat by requester k:
  - pointer <= (k+1) mod NUM_REQ.
  - ARB→LOCKED with owner<=k if req_lock[k]=1.
  - LOCKED→ARB when the owner's accepted beat has req_lock=0.
  - In LOCKED, owner holding req=0 with req_lock=1 keeps ownership (idle bubble). Owner with req=0 and req_lock=0 releases the same cycle; the new state is ARB next cycle.
- RAM bus, same cycle as the grant (combinational from the granted requester):
  - chipselect=|(req&gnt); write=req_write[k]; address, be and wdata are muxed from k.
  - When no grant: chipselect=0, write=0, address/be/wdata held at 0.
- Read response:
  - Each accepted read pushes {valid, id=k} into a READ_LATENCY-deep shift register.
  - At its output, rvalid[id] and rdata=ram_readdata are registered, so total latency is READ_LATENCY+1 cycles from acceptance. The extra register absorbs the RAM output path timing.
  - Writes produce no response. Back-to-back reads give one rvalid per cycle, in order.
- Read-after-write to the same address in consecutive cycles returns the new data; the RAM is configured for new-data read-during-write.
- Throughput: one beat per cycle, 100% utilisation with continuous requests.
- Fairness: with all requesters active and no locks, each requester is granted once every NUM_REQ cycles.

Decomposition:
- Shared package fpga_mem_pkg:
  - M10K_ADDR_W=8, M10K_DATA_W=32, M10K_BE_W=4.
  - typedef enum logic {ARB, LOCKED} arb_state_t.
  - typedef struct {logic valid; logic [2:0] id;} rd_tag_t.
- Sub-module rr_picker: a pure-combinational one-hot round-robin select from a request vector and pointer, reused by other arbiters.

Test Plan:
- Reset with req=4'b1111 held → gnt=0, ram_chipselect=0 while reset_n=0. First cycle after release gnt=4'b0001, then 0010, 0100, 1000, 0001.
- Requester 2 writes 0xDEADBEEF to address 0x10 (be=4'hF); next cycle requester 0 reads 0x10 → rvalid=4'b0001 two cycles after the read, rdata=0xDEADBEEF.
- Requester 1 issues 4 beats with req_lock=1,1,1,0 while req0 and req3 stay high → gnt=4'b0010 for 4 consecutive cycles, then gnt=4'b1000 (pointer=2).
- Requesters 0 and 3 issue interleaved back-to-back reads of 0x00 and 0xFF, preloaded with 0x1 and 0x2 → rvalid alternates 0001/1000 every cycle; rdata alternates 0x1/0x2 in issue order.
- Reset asserted one cycle after an accepted read → no rvalid ever appears for it. State returns to ARB, and the first post-reset grant follows pointer=0.
- Write with be=4'b0011 data 0xAAAA5555 over 0x12345678 at 0x20, then read → rdata=0x12345555.
